gpu_fb: RTL
===========

Name: gpu_fb

Overview:
- Parametrised successor to the CHIP-8 GPU command block. It adds an internal 1-bit-per-pixel framebuffer and executes CLEAR and DRAW commands.
- DRAW performs sprite XOR-blit with collision detection. Sprite rows are fetched from main memory through a 1-cycle-latency read port.
- Supports 64x32 (CHIP-8) and 128x64 (SCHIP) geometries, plus clip or wrap edge modes. A registered row port feeds scanout.

Parameters:
- WIDTH, 64, framebuffer width in pixels; power of 2, >= 8.
- HEIGHT, 32, framebuffer height in rows; power of 2.
- WRAP, 0, 0 = clip sprite pixels past the right/bottom edge; 1 = wrap them modulo WIDTH/HEIGHT.
- MAX_LEN, 15, maximum sprite rows; larger gpu_draw_length values are clamped to this.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- gpu_cmd  in  4  command: 0 = CLEAR, 1 = DRAW, others = NOP.
- gpu_draw_offset  in  16  sprite base address in main memory.
- gpu_draw_x  in  8  sprite x origin.
- gpu_draw_y  in  8  sprite y origin.
- gpu_draw_length  in  8  sprite rows.
- gpu_cmd_submitted  in  1  command strobe.
- gpu_collision  out  1  result of the last DRAW.
- gpu_ready  out  1  idle, accepting a command.
- mem_rd  out  1  memory read request.
- mem_addr  out  16  memory read address.
- mem_data  in  8  read data, valid the cycle after mem_rd.
- disp_row  in  log2(HEIGHT)  scanout row select.
- disp_pixels  out  WIDTH  scanout row data; bit WIDTH-1 is x=0.

Behaviour:
- Reset (async, rst_n=0):
  - state=WAIT_FOR_CMD, gpu_collision=0, mem_rd=0, mem_addr=0, disp_pixels=0, row counter=0.
  - Framebuffer is not reset; contents are undefined until the first CLEAR.
  - Reset mid-command aborts the command immediately; no further framebuffer writes occur.
- gpu_ready = (state==WAIT_FOR_CMD), combinational from state.
- Command acceptance:
  - On an edge with gpu_ready=1 and gpu_cmd_submitted=1, latch cmd, offset, x mod WIDTH, y mod HEIGHT, and len=min(length,MAX_LEN). Go to DECODE.
  - gpu_cmd_submitted while busy is ignored; there is no queueing.
  - Inputs need only be stable on the accept edge.
- DECODE (1 cycle):
  - CLEAR -> CLEARING, row counter=0.
  - DRAW with len=0 -> WAIT_FOR_CMD, gpu_collision=0.
  - DRAW with len>0 -> READ, r=0, gpu_collision=0.
  - NOP -> WAIT_FOR_CMD; no effect on collision or framebuffer.
- CLEARING:
  - Zero framebuffer row c each cycle; c increments.
  - After row HEIGHT-1 -> WAIT_FOR_CMD.
  - gpu_collision is unchanged.
  - gpu_ready rises HEIGHT+2 edges after the accept edge.
- READ:
  - mem_rd=1, mem_addr=(offset+r) mod 2^16 (wraps past 0xFFFF). Go to DATA.
- DATA:
  - mem_rd=0. Sample mem_data as byte b.
  - Target row ty=(y+r); if WRAP, ty mod HEIGHT; if not WRAP and ty>=HEIGHT, skip the row (no write, no collision).
  - Bit 7-i of b maps to column x+i, i=0..7.
  - Column >= WIDTH: wraps if WRAP, else is dropped.
  - Each set bit XORs its pixel. Any pixel changing 1->0 sets gpu_collision=1 (sticky for this DRAW).
  - Row write and collision update happen on the DATA exit edge.
  - r==len-1 -> WAIT_FOR_CMD, else r+1 -> READ.
- DRAW timing: gpu_ready rises 2+2*len edges after the accept edge.
- gpu_collision holds its value from the end of a DRAW until the DECODE of the next DRAW.
- Scanout:
  - disp_pixels <= framebuffer[disp_row] every edge (1-cycle latency), independent of state.
  - Same-edge write and read of a row returns the old contents.
- Widths: x/y are reduced modulo WIDTH/HEIGHT before use; column arithmetic is log2(WIDTH)+1 bits to detect overflow.

Test Plan:
- Reset then CLEAR (64x32):
  - ready low for 34 edges, then high.
  - All 32 disp_pixels rows read 0.
  - collision=0.
- DRAW at x=0, y=0, len=5, offset=0x050, memory 0xF0,0x90,0x90,0x90,0xF0 (font "0"):
  - 5 mem_rd pulses at addresses 0x050..0x054, each followed by a DATA cycle.
  - Row0 top byte=0xF0, row1=0x90.
  - collision=0; ready 12 edges after accept.
- Repeat the same DRAW: all five rows return to 0, collision=1.
- DRAW x=60, y=30, len=4, byte 0xFF:
  - WRAP=0: rows 30,31 have bits x=60..63 set, and rows 0,1 stay 0.
  - WRAP=1: columns 0..3 are also set, and rows 0,1 are also written.
- DRAW x=200, len=20 with MAX_LEN=15: x uses 200 mod 64=8; exactly 15 reads occur; ready after 32 edges.
- Submit a second command while busy, then assert rst_n=0 mid-DRAW:
  - The second command is ignored.
  - On reset, ready=1, collision=0, and mem_rd=0 immediately.
  - DRAW with len=0: no reads, ready after 2 edges, collision=0.

Source files
------------

// File: rtl/gpu_fb.sv
// CHIP-8/SCHIP GPU command block with an internal 1bpp framebuffer.
// Executes CLEAR and DRAW (XOR sprite blit with collision) and serves a registered scanout row.
module gpu_fb #(
  parameter int WIDTH   = 64,
  parameter int HEIGHT  = 32,
  parameter int WRAP    = 0,
  parameter int MAX_LEN = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3:0]                gpu_cmd,
  input  logic [15:0]               gpu_draw_offset,
  input  logic [7:0]                gpu_draw_x,
  input  logic [7:0]                gpu_draw_y,
  input  logic [7:0]                gpu_draw_length,
  input  logic                      gpu_cmd_submitted,
  output logic                      gpu_collision,
  output logic                      gpu_ready,
  output logic                      mem_rd,
  output logic [15:0]               mem_addr,
  input  logic [7:0]                mem_data,
  input  logic [$clog2(HEIGHT)-1:0] disp_row,
  output logic [WIDTH-1:0]          disp_pixels
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [3:0] CMD_CLEAR = 4'd0;
  localparam logic [3:0] CMD_DRAW  = 4'd1;

  typedef enum logic [2:0] {WAIT_FOR_CMD, DECODE, CLEARING, READ, DATA} state_t;

  state_t         state;
  logic [3:0]     cmd_q;
  logic [15:0]    offset_q;
  logic [XW-1:0]  x_q;
  logic [YW-1:0]  y_q;
  logic [7:0]     len_q;
  logic [7:0]     r_q;
  logic [YW-1:0]  clr_row;

  logic [WIDTH-1:0] fb [HEIGHT];

  logic [15:0]      ty_full;
  logic [YW-1:0]    ty;
  logic             row_ok;
  logic [XW:0]      col;
  logic [WIDTH-1:0] sprite_mask;
  logic [WIDTH-1:0] old_row;
  logic             hit;

  assign gpu_ready = (state == WAIT_FOR_CMD);

  // Sprite row placement: one extra column bit flags overflow past the right edge.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so no latch is inferred.
    ty_full     = 16'(y_q) + 16'(r_q);
    ty          = ty_full[YW-1:0];
    row_ok      = (WRAP != 0) || (ty_full < 16'(HEIGHT));
    col         = '0;
    sprite_mask = '0;
    for (int i = 0; i < 8; i++) begin
      col = {1'b0, x_q} + (XW+1)'(i);
      if (mem_data[7-i] && ((WRAP != 0) || !col[XW]))
        sprite_mask[~col[XW-1:0]] = 1'b1;  // x=0 lives in bit WIDTH-1
    end
    old_row = fb[ty];
    hit     = |(old_row & sprite_mask);
  end

  // NOTE: the framebuffer array has no reset; CLEAR defines it, and writes are gated by the reset state.
  always_ff @(posedge clk) begin
    if (state == CLEARING)
      fb[clr_row] <= '0;
    else if (state == DATA && row_ok)
      fb[ty] <= old_row ^ sprite_mask;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= WAIT_FOR_CMD;
      cmd_q         <= '0;
      offset_q      <= '0;
      x_q           <= '0;
      y_q           <= '0;
      len_q         <= '0;
      r_q           <= '0;
      clr_row       <= '0;
      gpu_collision <= 1'b0;
      mem_rd        <= 1'b0;
      mem_addr      <= '0;
      disp_pixels   <= '0;
    end else begin
      disp_pixels <= fb[disp_row];
      case (state)
        WAIT_FOR_CMD: if (gpu_cmd_submitted) begin
          cmd_q    <= gpu_cmd;
          offset_q <= gpu_draw_offset;
          x_q      <= XW'(gpu_draw_x);
          y_q      <= YW'(gpu_draw_y);
          len_q    <= (gpu_draw_length > 8'(MAX_LEN)) ? 8'(MAX_LEN) : gpu_draw_length;
          state    <= DECODE;
        end
        DECODE: begin
          case (cmd_q)
            CMD_CLEAR: begin
              clr_row <= '0;
              state   <= CLEARING;
            end
            CMD_DRAW: begin
              gpu_collision <= 1'b0;
              if (len_q == 8'd0) begin
                state <= WAIT_FOR_CMD;
              end else begin
                r_q      <= '0;
                mem_rd   <= 1'b1;
                mem_addr <= offset_q;
                state    <= READ;
              end
            end
            default: state <= WAIT_FOR_CMD;
          endcase
        end
        CLEARING: begin
          clr_row <= clr_row + 1'b1;
          if (&clr_row) state <= WAIT_FOR_CMD;
        end
        READ: begin
          mem_rd <= 1'b0;
          state  <= DATA;
        end
        DATA: begin
          if (row_ok && hit) gpu_collision <= 1'b1;
          if (r_q == len_q - 8'd1) begin
            state <= WAIT_FOR_CMD;
          end else begin
            r_q      <= r_q + 8'd1;
            mem_rd   <= 1'b1;
            mem_addr <= offset_q + 16'(r_q) + 16'd1;
            state    <= READ;
          end
        end
        default: state <= WAIT_FOR_CMD;
      endcase
    end
  end

endmodule
